i2c_system_top: RTL and testbench

Self-contained I2C system: one I2C master plus three I2C slaves on an internal open-drain SDA/SCL bus. The slaves are LED output (0x55), 7-segment FND output (0x56) and switch input (0x57). A host issues single-byte write/read transactions through a start/busy/done handshake. Debug outputs expose address matches and FSM states for bring-up and FPGA demo use.

---
 rtl/i2c_pkg.sv | 57 +++++
 rtl/i2c_slave_core.sv | 137 +++++++++++++
 rtl/i2c_system_top.sv | 192 +++++++++++++++++++
 tb/tb_i2c_system_top.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C system: master/slave state encodings, default
// slave addresses and the seven-segment decoder.
package i2c_pkg;

  typedef enum logic [4:0] {
    M_IDLE      = 5'd0,
    M_START     = 5'd1,
    M_ADDR      = 5'd2,
    M_ADDR_ACK  = 5'd3,
    M_WRITE     = 5'd4,
    M_WRITE_ACK = 5'd5,
    M_READ      = 5'd6,
    M_READ_NACK = 5'd7,
    M_STOP      = 5'd8,
    M_DONE      = 5'd9
  } master_state_t;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ADDR       = 4'd1,
    S_ADDR_ACK   = 4'd2,
    S_WRITE_DATA = 4'd3,
    S_WRITE_ACK  = 4'd4,
    S_READ_DATA  = 4'd5,
    S_READ_ACK   = 4'd6,
    S_WAIT_STOP  = 4'd7
  } slave_state_t;

  localparam logic [6:0] LED_ADDR_DEF = 7'h55;
  localparam logic [6:0] FND_ADDR_DEF = 7'h56;
  localparam logic [6:0] SW_ADDR_DEF  = 7'h57;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/i2c_slave_core.sv
// Generic single-byte I2C slave: address decode, write-byte capture with
// ACK, and read-byte shift-out. Bus edges are detected by registering SCL/SDA.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  input  logic [7:0] rd_data,
  output logic       sda_pull,
  output logic       wr_strobe,
  output logic [7:0] wr_data,
  output logic       addr_match,
  output logic [3:0] state
);

  slave_state_t st, st_nx;
  logic       scl_q, sda_q;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic       rw_q;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;
  assign rx_byte   = {shreg, sda};
  assign state     = st;

  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nx;
  end

  // ACK states span two SCL falls: the first asserts the pull, the second
  // (seen with the pull already active) ends the ACK bit.
  always_comb begin
    st_nx = st;
    if (start_det)     st_nx = S_ADDR;
    else if (stop_det) st_nx = S_IDLE;
    else begin
      case (st)
        S_ADDR:
          if (scl_rise && bit_cnt == 3'd7)
            st_nx = (rx_byte[7:1] == ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK:
          if (scl_fall && sda_pull) st_nx = rw_q ? S_READ_DATA : S_WRITE_DATA;
        S_WRITE_DATA:
          if (scl_rise && bit_cnt == 3'd7) st_nx = S_WRITE_ACK;
        S_WRITE_ACK:
          if (scl_fall && sda_pull) st_nx = S_WAIT_STOP;
        S_READ_DATA:
          if (scl_fall && bit_cnt == 3'd7) st_nx = S_READ_ACK;
        S_READ_ACK:
          if (scl_fall) st_nx = S_WAIT_STOP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      shreg      <= '0;
      bit_cnt    <= '0;
      rw_q       <= 1'b0;
      sda_pull   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_data    <= '0;
      addr_match <= 1'b0;
    end else begin
      scl_q     <= scl;
      sda_q     <= sda;
      wr_strobe <= 1'b0;
      if (start_det) begin
        bit_cnt    <= '0;
        sda_pull   <= 1'b0;
        addr_match <= 1'b0;
      end else if (stop_det) begin
        sda_pull   <= 1'b0;
        addr_match <= 1'b0;
      end else begin
        case (st)
          S_ADDR:
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw_q       <= rx_byte[0];
                addr_match <= (rx_byte[7:1] == ADDR);
              end
            end
          S_ADDR_ACK:
            if (scl_fall) begin
              bit_cnt <= '0;
              if (!sda_pull) sda_pull <= 1'b1;
              else if (rw_q) begin
                shreg    <= rd_data[6:0];
                sda_pull <= ~rd_data[7];
              end else sda_pull <= 1'b0;
            end
          S_WRITE_DATA:
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) wr_data <= rx_byte;
            end
          S_WRITE_ACK:
            if (scl_fall) begin
              if (!sda_pull) sda_pull <= 1'b1;
              else begin
                sda_pull  <= 1'b0;
                wr_strobe <= 1'b1;
              end
            end
          S_READ_DATA:
            if (scl_fall) begin
              if (bit_cnt == 3'd7) sda_pull <= 1'b0;
              else begin
                bit_cnt  <= bit_cnt + 3'd1;
                sda_pull <= ~shreg[6];
                shreg    <= {shreg[5:0], 1'b0};
              end
            end
          default: sda_pull <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/i2c_system_top.sv
// I2C master with host handshake plus LED, FND and switch slaves on an
// internal open-drain bus.
module i2c_system_top
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 250,
  parameter logic [6:0]  LED_ADDR = LED_ADDR_DEF,
  parameter logic [6:0]  FND_ADDR = FND_ADDR_DEF,
  parameter logic [6:0]  SW_ADDR  = SW_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw_bit,
  input  logic [6:0] slave_addr,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  input  logic [7:0] SW,
  output logic [7:0] LED,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       debug_addr_match_led,
  output logic       debug_addr_match_fnd,
  output logic       debug_addr_match_sw,
  output logic [4:0] debug_master_state,
  output logic [3:0] debug_led_state,
  output logic [3:0] debug_fnd_state,
  output logic [3:0] debug_sw_state
);

  master_state_t m_st, m_nx;
  logic [15:0] div_cnt;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, tx_q;
  logic        rw_q;
  logic        tick, bit_end;
  logic        m_scl, m_sda, sda_bus, scl_bus;
  logic        led_pull, fnd_pull, sw_pull;
  logic        led_wr, fnd_wr, sw_wr;
  logic [7:0]  led_wdata, fnd_wdata, sw_wdata;
  logic [3:0]  fnd_digit;
  logic        sw_unused;

  assign tick    = (div_cnt == 16'(CLK_DIV - 1));
  assign bit_end = tick && (phase == 2'd3);
  assign scl_bus = m_scl;
  assign sda_bus = m_sda & ~led_pull & ~fnd_pull & ~sw_pull;

  assign busy               = (m_st != M_IDLE);
  assign done               = (m_st == M_DONE);
  assign debug_master_state = m_st;
  assign SEG                = seg7(fnd_digit);
  assign AN                 = 4'b1110;
  assign sw_unused          = &{1'b0, sw_wr, sw_wdata, fnd_wdata[7:4]};

  always_ff @(posedge clk) begin
    if (rst) m_st <= M_IDLE;
    else     m_st <= m_nx;
  end

  always_comb begin
    m_nx  = m_st;
    m_scl = 1'b1;
    m_sda = 1'b1;
    case (m_st)
      M_IDLE: if (start) m_nx = M_START;
      M_START: begin
        m_scl = (phase != 2'd3);
        m_sda = (phase == 2'd0);
        if (bit_end) m_nx = M_ADDR;
      end
      M_ADDR: begin
        m_scl = phase[1];
        m_sda = shreg[7];
        if (bit_end && bit_cnt == 3'd0) m_nx = M_ADDR_ACK;
      end
      M_ADDR_ACK: begin
        m_scl = phase[1];
        if (bit_end) m_nx = ack_error ? M_STOP : (rw_q ? M_READ : M_WRITE);
      end
      M_WRITE: begin
        m_scl = phase[1];
        m_sda = shreg[7];
        if (bit_end && bit_cnt == 3'd0) m_nx = M_WRITE_ACK;
      end
      M_WRITE_ACK: begin
        m_scl = phase[1];
        if (bit_end) m_nx = M_STOP;
      end
      M_READ: begin
        m_scl = phase[1];
        if (bit_end && bit_cnt == 3'd0) m_nx = M_READ_NACK;
      end
      M_READ_NACK: begin
        m_scl = phase[1];
        if (bit_end) m_nx = M_STOP;
      end
      M_STOP: begin
        m_scl = (phase != 2'd0);
        m_sda = phase[1];
        if (bit_end) m_nx = M_DONE;
      end
      M_DONE: m_nx = M_IDLE;
      default: m_nx = M_IDLE;
    endcase
  end

  // Samples are taken at the end of the first SCL-high quarter; bit-level
  // bookkeeping happens at the end of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      rx_data   <= '0;
      ack_error <= 1'b0;
    end else if (m_st == M_IDLE) begin
      div_cnt <= '0;
      phase   <= '0;
      if (start) begin
        shreg     <= {slave_addr, rw_bit};
        tx_q      <= tx_data;
        rw_q      <= rw_bit;
        bit_cnt   <= 3'd7;
        ack_error <= 1'b0;
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 16'd1;
      if (tick) phase <= phase + 2'd1;
      if (tick && phase == 2'd2) begin
        case (m_st)
          M_ADDR_ACK, M_WRITE_ACK: if (sda_bus) ack_error <= 1'b1;
          M_READ: shreg <= {shreg[6:0], sda_bus};
          default: ;
        endcase
      end
      if (bit_end) begin
        case (m_st)
          M_ADDR, M_WRITE: begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
          M_ADDR_ACK: begin
            shreg   <= tx_q;
            bit_cnt <= 3'd7;
          end
          M_READ: begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) rx_data <= shreg;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      LED       <= '0;
      fnd_digit <= '0;
    end else begin
      if (led_wr) LED <= led_wdata;
      if (fnd_wr) fnd_digit <= fnd_wdata[3:0];
    end
  end

  i2c_slave_core #(.ADDR(LED_ADDR)) u_led (
    .clk(clk), .rst(rst), .scl(scl_bus), .sda(sda_bus), .rd_data(8'hFF),
    .sda_pull(led_pull), .wr_strobe(led_wr), .wr_data(led_wdata),
    .addr_match(debug_addr_match_led), .state(debug_led_state)
  );

  i2c_slave_core #(.ADDR(FND_ADDR)) u_fnd (
    .clk(clk), .rst(rst), .scl(scl_bus), .sda(sda_bus), .rd_data(8'hFF),
    .sda_pull(fnd_pull), .wr_strobe(fnd_wr), .wr_data(fnd_wdata),
    .addr_match(debug_addr_match_fnd), .state(debug_fnd_state)
  );

  i2c_slave_core #(.ADDR(SW_ADDR)) u_sw (
    .clk(clk), .rst(rst), .scl(scl_bus), .sda(sda_bus), .rd_data(SW),
    .sda_pull(sw_pull), .wr_strobe(sw_wr), .wr_data(sw_wdata),
    .addr_match(debug_addr_match_sw), .state(debug_sw_state)
  );

endmodule

// File: tb/tb_i2c_system_top.sv
// Self-checking bench for i2c_system_top: directed and randomized single-byte
// transactions compared against a register-level model of the three slaves.
module tb_i2c_system_top;

  logic       clk = 1'b0;
  logic       rst, start, rw_bit;
  logic [6:0] slave_addr;
  logic [7:0] tx_data, rx_data, SW, LED;
  logic       busy, done, ack_error;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       dm_led, dm_fnd, dm_sw;
  logic [4:0] dbg_m;
  logic [3:0] dbg_led, dbg_fnd, dbg_sw;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] m_led, m_rx;
  logic [3:0] m_digit;
  logic       m_ack;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  i2c_system_top #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rw_bit(rw_bit), .slave_addr(slave_addr),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done), .ack_error(ack_error),
    .SW(SW), .LED(LED), .SEG(SEG), .AN(AN),
    .debug_addr_match_led(dm_led), .debug_addr_match_fnd(dm_fnd), .debug_addr_match_sw(dm_sw),
    .debug_master_state(dbg_m), .debug_led_state(dbg_led), .debug_fnd_state(dbg_fnd),
    .debug_sw_state(dbg_sw)
  );

  task automatic model_reset();
    m_led = 8'h00; m_rx = 8'h00; m_digit = 4'h0; m_ack = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b want 0", tag, done); end
    n_cmp++; if (rx_data !== m_rx) begin n_fail++; $display("FAIL %s rx_data: got %h want %h", tag, rx_data, m_rx); end
    n_cmp++; if (ack_error !== m_ack) begin n_fail++; $display("FAIL %s ack_error: got %b want %b", tag, ack_error, m_ack); end
    n_cmp++; if (LED !== m_led) begin n_fail++; $display("FAIL %s LED: got %h want %h", tag, LED, m_led); end
    n_cmp++; if (SEG !== seg_tab[m_digit]) begin n_fail++; $display("FAIL %s SEG: got %b want %b", tag, SEG, seg_tab[m_digit]); end
    n_cmp++; if (AN !== 4'b1110) begin n_fail++; $display("FAIL %s AN: got %b want 1110", tag, AN); end
    n_cmp++;
    if ({dm_led, dm_fnd, dm_sw, dbg_m, dbg_led, dbg_fnd, dbg_sw} !== 20'h0) begin
      n_fail++;
      $display("FAIL %s debug: got m=%0d led=%0d fnd=%0d sw=%0d match=%b%b%b want all 0",
               tag, dbg_m, dbg_led, dbg_fnd, dbg_sw, dm_led, dm_fnd, dm_sw);
    end
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] a, input logic [7:0] d,
                         input int poke_at, input string tag);
    int  done_cnt;
    bit  finished, seen_led, seen_fnd, seen_sw, hit;
    done_cnt = 0; finished = 0; seen_led = 0; seen_fnd = 0; seen_sw = 0;
    @(negedge clk);
    rw_bit = rw; slave_addr = a; tx_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy); end
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (done === 1'b1) done_cnt++;
      else if (done_cnt > 0) finished = 1;
      if (dm_led === 1'b1) seen_led = 1;
      if (dm_fnd === 1'b1) seen_fnd = 1;
      if (dm_sw === 1'b1) seen_sw = 1;
      if (!finished) begin
        if (cyc == poke_at) begin
          start = 1'b1; rw_bit = 1'b0; slave_addr = 7'h56; tx_data = ~d;
        end else begin
          start = 1'b0; rw_bit = rw; slave_addr = a; tx_data = d;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    n_cmp++; if (!finished) begin n_fail++; $display("FAIL %s completion: got done_count=%0d within budget, want one pulse", tag, done_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL %s done_width: got %0d cycles want 1", tag, done_cnt); end
    hit = (a == 7'h55) || (a == 7'h56) || (a == 7'h57);
    if (!hit) m_ack = 1'b1;
    else begin
      m_ack = 1'b0;
      if (rw) m_rx = (a == 7'h57) ? SW : 8'hFF;
      else if (a == 7'h55) m_led = d;
      else if (a == 7'h56) m_digit = d[3:0];
    end
    n_cmp++;
    if ({seen_led, seen_fnd, seen_sw} !== {a == 7'h55, a == 7'h56, a == 7'h57}) begin
      n_fail++;
      $display("FAIL %s addr_match_seen: got %b%b%b want %b%b%b", tag, seen_led, seen_fnd, seen_sw,
               a == 7'h55, a == 7'h56, a == 7'h57);
    end
    check_idle_outputs(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rw_bit = 1'b0; slave_addr = '0; tx_data = '0; SW = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle_outputs("reset");
  endtask

  task automatic test_led_write();
    run_txn(1'b0, 7'h55, 8'hFF, -1, "led_write");
  endtask

  task automatic test_fnd_write();
    run_txn(1'b0, 7'h56, 8'h05, -1, "fnd_write");
    n_cmp++; if (SEG !== 7'b0010010) begin n_fail++; $display("FAIL fnd5_seg: got %b want 0010010", SEG); end
  endtask

  task automatic test_sw_read();
    SW = 8'hCD;
    run_txn(1'b1, 7'h57, 8'h00, -1, "sw_read");
    n_cmp++; if (rx_data !== 8'hCD) begin n_fail++; $display("FAIL sw_read_cd: got %h want cd", rx_data); end
  endtask

  task automatic test_no_slave();
    run_txn(1'b0, 7'h19, 8'hFF, -1, "no_slave");
    repeat (20) @(negedge clk);
    n_cmp++; if (ack_error !== 1'b1) begin n_fail++; $display("FAIL ack_error_hold: got %b want 1", ack_error); end
  endtask

  task automatic test_busy_ignore();
    int busy_cnt;
    busy_cnt = 0;
    run_txn(1'b0, 7'h55, 8'hA5, 60, "busy_ignore");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
    end
    n_cmp++; if (busy_cnt != 0) begin n_fail++; $display("FAIL busy_after_ignore: got %0d busy cycles want 0", busy_cnt); end
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic [7:0] d;
    logic       rw;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0: a = 7'h55;
        1: a = 7'h56;
        2: a = 7'h57;
        default: a = 7'($urandom);
      endcase
      d  = 8'($urandom);
      rw = 1'($urandom);
      SW = 8'($urandom);
      run_txn(rw, a, d, -1, "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    rw_bit = 1'b0; slave_addr = 7'h55; tx_data = 8'h3C; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (150) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_idle_outputs("reset_mid");
    repeat (400) @(negedge clk);
    check_idle_outputs("reset_mid_settle");
  endtask

  task automatic test_fnd_seq();
    run_txn(1'b0, 7'h56, 8'h0A, -1, "fnd_0a");
    n_cmp++; if (SEG !== 7'b0001000) begin n_fail++; $display("FAIL fnd_a_seg: got %b want 0001000", SEG); end
    run_txn(1'b0, 7'h56, 8'h3F, -1, "fnd_3f");
    n_cmp++; if (SEG !== 7'b0001110) begin n_fail++; $display("FAIL fnd_f_seg: got %b want 0001110", SEG); end
  endtask

  initial begin
    test_reset();
    test_led_write();
    test_fnd_write();
    test_sw_read();
    test_no_slave();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    test_fnd_seq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
